alu_exec_stage: RTL
===================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, operand/result width; only 32 supported.
REQ-002 SHALL have port: i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_valid  input  1  decode presents an operation.
REQ-005 SHALL have port: o_ready  output  1  stage accepts operation this cycle.
REQ-006 SHALL have ports: i_alu_op  input  6  ALU opcode; i_a, i_b  input  32  operands; i_rd  input  5  destination tag.
REQ-007 SHALL have port: o_valid  output  1  result held for writeback.
REQ-008 SHALL have port: i_ready  input  1  writeback consumes result.
REQ-009 SHALL have ports: o_result  output  32  result; o_rd  output  5  tag of o_result.
REQ-010 SHALL have port: o_busy  output  1  multi-cycle operation in progress.

Function
REQ-011 SHALL transfer input on i_valid && o_ready and output on o_valid && i_ready.
REQ-012 SHALL use states IDLE, CALC, HOLD: IDLE = output empty; HOLD = result held; CALC = iterative MUL/DIV running.
REQ-013 SHALL drive o_ready = (state==IDLE) || (state==HOLD && i_ready); low in CALC.
REQ-014 SHALL compute single-cycle opcodes (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA, INV, NOP) via the combinational ALU; result registered, o_valid the cycle after acceptance (latency 1).
REQ-015 SHALL sustain one operation per cycle when i_valid and i_ready are both held high (HOLD->HOLD with new result).
REQ-016 SHALL produce 0 for unknown opcodes, and SHALL NOT pass ALU output unassigned for any opcode.
REQ-017 SHALL, on HOLD with i_ready and no new input, go to IDLE and drop o_valid next cycle.
REQ-018 SHALL hold o_result/o_rd stable while o_valid && !i_ready.
REQ-019 SHALL, on accepted MUL/DIV (MULDIV_EN defined), enter CALC, assert o_busy, run exactly 32 iterations, then enter HOLD; o_valid 33 cycles after acceptance.
REQ-020 SHALL compute MUL as low 32 bits of unsigned product (shift-add, 1 bit/cycle).
REQ-021 SHALL compute DIV as unsigned restoring-division quotient; divisor 0 -> 32'hFFFFFFFF, full 32 cycles still taken.
REQ-022 SHALL capture operands, opcode, tag at acceptance; input changes during CALC have no effect.

Reset
REQ-023 SHALL, while i_rst_n low, force state IDLE, o_valid=0, o_busy=0, o_result=0, o_rd=0, iteration counter 0; o_ready=1 after release.
REQ-024 SHALL abort an in-flight CALC on reset with no result emitted.

Configuration
REQ-025 SHALL compile the iterative MUL/DIV unit only when ALU_EXEC_MULDIV_EN is defined.
REQ-026 SHALL, without ALU_EXEC_MULDIV_EN, treat MUL/DIV as single-cycle with result 0; CALC unreachable, o_busy tied 0.

Structure
REQ-027 SHALL take opcode constants (OP_ALU_*), DATA_WIDTH and the state encoding from shared package alu_pkg.
REQ-028 SHALL instance the existing alu module as its only sub-module; MUL/DIV datapath inline.

Verification
REQ-029 SHALL cover: ADD a=5,b=7 accepted cycle N, i_ready=1 -> o_valid cycle N+1, o_result=12.
REQ-030 SHALL cover: SUB 3-5 then SRA 32'h80000000>>4 back-to-back -> 32'hFFFFFFFE then 32'hF8000000 on consecutive cycles.
REQ-031 SHALL cover: i_ready=0 for 3 cycles with XOR F0^FF held -> o_result=0x0F stable, o_ready=0, then drains.
REQ-032 SHALL cover (MULDIV_EN): MUL 1234*5678 -> o_busy 32 cycles, o_result=7006652 at cycle N+33; DIV 100/0 -> 32'hFFFFFFFF.
REQ-033 SHALL cover: reset asserted mid-CALC at iteration 10 -> outputs 0 immediately, no o_valid after release.
REQ-034 SHALL cover: opcode 6'b111111, a=1,b=1 -> o_result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared operand width, ALU opcode map and exec-stage state encoding
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] OP_ALU_NOP = 6'h00;
    localparam logic [5:0] OP_ALU_ADD = 6'h01;
    localparam logic [5:0] OP_ALU_SUB = 6'h02;
    localparam logic [5:0] OP_ALU_AND = 6'h03;
    localparam logic [5:0] OP_ALU_OR  = 6'h04;
    localparam logic [5:0] OP_ALU_XOR = 6'h05;
    localparam logic [5:0] OP_ALU_SLT = 6'h06;
    localparam logic [5:0] OP_ALU_SLL = 6'h07;
    localparam logic [5:0] OP_ALU_SRL = 6'h08;
    localparam logic [5:0] OP_ALU_SRA = 6'h09;
    localparam logic [5:0] OP_ALU_INV = 6'h0A;
    localparam logic [5:0] OP_ALU_MUL = 6'h0B;
    localparam logic [5:0] OP_ALU_DIV = 6'h0C;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational ALU; NOP, MUL, DIV and unknown opcodes yield 0
module alu
    import alu_pkg::*;
(
    input  logic [5:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // opcode decode; every path assigns y so no opcode leaves it undriven
    always_comb begin
        case (op)
            OP_ALU_ADD: y = a + b;
            OP_ALU_SUB: y = a - b;
            OP_ALU_AND: y = a & b;
            OP_ALU_OR:  y = a | b;
            OP_ALU_XOR: y = a ^ b;
            OP_ALU_SLT: y = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_ALU_SLL: y = a << b[4:0];
            OP_ALU_SRL: y = a >> b[4:0];
            OP_ALU_SRA: y = $signed(a) >>> b[4:0];
            OP_ALU_INV: y = ~a;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: valid/ready execute stage around alu with a result hold register;
// define ALU_EXEC_MULDIV_EN to add the iterative 32-cycle MUL/DIV unit
module alu_exec_stage #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_alu_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [4:0]            i_rd,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [4:0]            o_rd,
    output logic                  o_busy
);
    import alu_pkg::*;

    state_t                state;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  accept;

    alu u_alu (
        .op (i_alu_op),
        .a  (i_a),
        .b  (i_b),
        .y  (alu_y)
    );

    assign o_ready = (state == IDLE) || (state == HOLD && i_ready);
    assign o_valid = state == HOLD;
    assign accept  = i_valid && o_ready;

`ifdef ALU_EXEC_MULDIV_EN
    // md_x: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // md_y: multiplier (MUL) or divisor (DIV); md_acc: product or remainder
    logic                  is_md, md_div, ge;
    logic [4:0]            cnt;
    logic [DATA_WIDTH-1:0] md_x, md_y, md_acc, mul_acc, div_rem, div_q;
    logic [DATA_WIDTH:0]   rem_sh;

    assign is_md   = i_alu_op == OP_ALU_MUL || i_alu_op == OP_ALU_DIV;
    assign o_busy  = state == CALC;
    assign mul_acc = md_y[0] ? md_acc + md_x : md_acc;
    assign rem_sh  = {md_acc, md_x[DATA_WIDTH-1]};
    assign ge      = rem_sh >= {1'b0, md_y};
    assign div_rem = ge ? DATA_WIDTH'(rem_sh - {1'b0, md_y}) : rem_sh[DATA_WIDTH-1:0];
    assign div_q   = {md_x[DATA_WIDTH-2:0], ge};

    // stage control plus one shift-add / restoring-division step per CALC cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_result <= '0;
            o_rd     <= '0;
            cnt      <= '0;
            md_div   <= 1'b0;
            md_x     <= '0;
            md_y     <= '0;
            md_acc   <= '0;
        end else if (state == CALC) begin
            cnt    <= cnt + 5'd1;
            md_x   <= md_div ? div_q : md_x << 1;
            md_y   <= md_div ? md_y : md_y >> 1;
            md_acc <= md_div ? div_rem : mul_acc;
            if (cnt == 5'd31) begin
                state    <= HOLD;
                o_result <= md_div ? div_q : mul_acc;
            end
        end else if (accept) begin
            state  <= is_md ? CALC : HOLD;
            o_rd   <= i_rd;
            cnt    <= '0;
            md_div <= i_alu_op == OP_ALU_DIV;
            md_x   <= i_a;
            md_y   <= i_b;
            md_acc <= '0;
            if (!is_md) o_result <= alu_y;
        end else if (state == HOLD && i_ready) begin
            state <= IDLE;
        end
    end
`else
    assign o_busy = 1'b0;

    // stage control: capture ALU result on accept, drop to IDLE once drained
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_result <= '0;
            o_rd     <= '0;
        end else if (accept) begin
            state    <= HOLD;
            o_result <= alu_y;
            o_rd     <= i_rd;
        end else if (state == HOLD && i_ready) begin
            state <= IDLE;
        end
    end
`endif

endmodule
